wb_addr_decoder: RTL
====================

# wb_addr_decoder

One-master, four-slave Wishbone classic address decoder with a bus-timeout watchdog. It sits directly downstream of the CPU's Wishbone master adapter.
- Routes each cycle to one slave by base/mask match.
- Returns the selected slave's read data and ack to the master.
- Terminates unmapped or hung accesses itself, acking with a fixed error word so the core's memory interface never stalls forever.
- Records the first fault in sticky status registers.

## Interface
Parameters:
- `SLV_BASE`, default {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: packed 4×32 base addresses, slave 0 in bits [31:0].
- `SLV_MASK`, default {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}: packed 4×32 masks; slave i hits when (adr & MASK[i]) == BASE[i].
- `TIMEOUT_CYCLES`, default 16: slave strobe cycles allowed before abort; legal range 2..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on unmapped or timed-out access.

Ports:
- `wb_clk_i` in 1: clock, all logic on rising edge.
- `wb_rst_n_i` in 1: reset, synchronous, active-low.
- `wbs_adr_i` in 32; `wbs_dat_i` in 32; `wbs_we_i` in 1; `wbs_sel_i` in 4; `wbs_stb_i` in 1; `wbs_cyc_i` in 1: master request.
- `wbs_dat_o` out 32: read data to master.
- `wbs_ack_o` out 1: ack to master.
- `wbm_adr_o` out 32; `wbm_dat_o` out 32; `wbm_we_o` out 1; `wbm_sel_o` out 4: broadcast to all slaves.
- `wbm_cyc_o` out 4; `wbm_stb_o` out 4: per-slave cycle and strobe.
- `wbm_dat_i` in 128: per-slave read data, slave i in [32i+31:32i].
- `wbm_ack_i` in 4: per-slave ack.
- `err_flag_o` out 1: sticky fault flag.
- `err_cause_o` out 2: 2'b01 unmapped, 2'b10 timeout.
- `err_adr_o` out 32: address of the captured fault.
- `err_clr_i` in 1: clears the sticky fault.

## Operation
- Broadcast outputs are combinational copies of the master inputs.
- States: IDLE, BUSY, ERR, DONE. Reset enters IDLE, clears the timeout counter, the select register and all `err_*` outputs.
- **IDLE:** when `wbs_cyc_i & wbs_stb_i`:
  - Decode `wbs_adr_i`; the lowest matching index wins.
  - On a hit, register the index in `sel_q` and go to BUSY.
  - On a miss, go to ERR with cause 01.
- **BUSY:** `wbm_cyc_o[sel_q]` and `wbm_stb_o[sel_q]` follow `wbs_cyc_i` and `wbs_stb_i`; all other bits are 0.
  - Slave ack: `wbs_ack_o = wbm_ack_i[sel_q]` and `wbs_dat_o = wbm_dat_i[sel_q]`, both combinational. Go to DONE.
  - No ack: the counter increments. If no ack arrives on the cycle the counter equals TIMEOUT_CYCLES-1, go to ERR with cause 10.
  - Master abort (`wbs_cyc_i` low): go to IDLE, clear the counter, no ack.
- **ERR:** all slave strobes are 0. Drive `wbs_ack_o=1` and `wbs_dat_o=ERR_DATA` for one cycle, then go to DONE.
- **DONE:** one dead cycle, with `wbs_ack_o=0` and the request ignored, then IDLE. This prevents re-decoding a strobe the master is still dropping.
- `wbs_dat_o` is 0 whenever `wbs_ack_o` is 0.
- Writes that error are discarded; ack is still given.
- **Fault capture:**
  - On entry to ERR with `err_flag_o=0`: set the flag and latch the cause and `wbs_adr_i`.
  - While the flag is set, later faults do not overwrite it.
  - `err_clr_i` clears the flag, cause and address.
  - If `err_clr_i` coincides with a new fault entry, the new fault is captured and the flag stays 1.

## Timing
- Request first seen in IDLE at cycle T.
- Slave strobe high at T+1. Master ack at the earliest at T+1, for a zero-wait slave.
- Unmapped access: ack with ERR_DATA at T+1.
- Hung slave:
  - Slave strobe is high for exactly TIMEOUT_CYCLES cycles, T+1..T+TIMEOUT_CYCLES.
  - Error ack at T+TIMEOUT_CYCLES+1.
  - A slave ack on the final counted cycle wins over timeout.
- Master ack is one cycle wide in all cases. The next request is accepted no earlier than two cycles after the ack.
- While `wb_rst_n_i` is low:
  - `wbm_cyc_o`, `wbm_stb_o` and `wbs_ack_o` are forced 0 combinationally.
  - State is IDLE after the reset edge. Reset mid-transaction drops the cycle with no ack.

## Structure
- A shared package holds the state enum, the cause codes (CAUSE_UNMAPPED=2'b01, CAUSE_TIMEOUT=2'b10) and NSLV=4.
- One sub-module, `wb_addr_match`: combinational priority base/mask matcher producing hit and a 2-bit index.
- The FSM, counter and fault registers live in the top level.

## Test plan
- Read 0x0000_0010, slave 0 acks 2 cycles after its strobe with 0x1234_5678 → only `wbm_stb_o[0]` high, `wbs_dat_o=0x1234_5678`, ack at T+3, DONE then IDLE.
- Write 0x2000_0004, data 0xA5A5_A5A5, sel 4'hF, zero-wait slave 2 → `wbm_stb_o=4'b0100`, ack at T+1, no fault.
- Read 0x4000_0000 (unmapped) → no slave strobe; ack at T+1 with 0xDEAD_BEEF; `err_flag_o=1`, `err_cause_o=01`, `err_adr_o=0x4000_0000`.
- Read 0x1000_0000 with slave 1 silent, TIMEOUT_CYCLES=16 → `wbm_stb_o[1]` high for 16 cycles; ack at T+17 with 0xDEAD_BEEF; cause 10. A second timeout leaves the captured address unchanged.
- Slave 3 acks exactly on the 16th strobe cycle → real data returned, no fault. `err_clr_i` pulsed in the same cycle as an unmapped fault entry → flag stays 1 with the new address.
- Assert reset during BUSY → strobes 0 in that cycle, no ack, `err_*` cleared, and the next request decodes normally.

Source files
------------

// File: rtl/wb_addr_decoder_pkg.sv
// Shared types and constants for the Wishbone address decoder.
package wb_addr_decoder_pkg;

  localparam int NSLV = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE     = 2'b00;
  localparam cause_t CAUSE_UNMAPPED = 2'b01;
  localparam cause_t CAUSE_TIMEOUT  = 2'b10;

endpackage

// File: rtl/wb_addr_decoder_if.sv
// Bus bundle between the CPU master adapter, the decoder and the four slaves.
interface wb_addr_decoder_if;
  import wb_addr_decoder_pkg::*;

  // master request side
  logic [31:0]        wbs_adr_i;
  logic [31:0]        wbs_dat_i;
  logic               wbs_we_i;
  logic [3:0]         wbs_sel_i;
  logic               wbs_stb_i;
  logic               wbs_cyc_i;
  logic [31:0]        wbs_dat_o;
  logic               wbs_ack_o;
  // slave fan-out side
  logic [31:0]        wbm_adr_o;
  logic [31:0]        wbm_dat_o;
  logic               wbm_we_o;
  logic [3:0]         wbm_sel_o;
  logic [NSLV-1:0]    wbm_cyc_o;
  logic [NSLV-1:0]    wbm_stb_o;
  logic [NSLV*32-1:0] wbm_dat_i;
  logic [NSLV-1:0]    wbm_ack_i;

  // view from the decoder
  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
    output wbs_dat_o, wbs_ack_o,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  // view from the surrounding system (CPU master plus slaves)
  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
    input  wbs_dat_o, wbs_ack_o,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_addr_decoder_match.sv
// Combinational base/mask matcher; the lowest matching slave index wins.
module wb_addr_match
  import wb_addr_decoder_pkg::*;
#(
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}
) (
  input  logic [31:0] adr_i,
  output logic        hit_o,
  output logic [1:0]  idx_o
);

  logic [NSLV-1:0] match_s;

  // per-slave window compare
  always_comb begin
    match_s = 4'b0000;
    for (int i = 0; i < NSLV; i++) begin
      match_s[i] = ((adr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]);
    end
  end

  // priority encode so overlapping windows resolve to the lowest index
  always_comb begin
    hit_o = |match_s;
    if (match_s[0]) begin
      idx_o = 2'd0;
    end else if (match_s[1]) begin
      idx_o = 2'd1;
    end else if (match_s[2]) begin
      idx_o = 2'd2;
    end else begin
      idx_o = 2'd3;
    end
  end

endmodule

// File: rtl/wb_addr_decoder.sv
// One-master / four-slave Wishbone classic decoder with bus-timeout watchdog
// and sticky first-fault capture.
module wb_addr_decoder
  import wb_addr_decoder_pkg::*;
#(
  parameter logic [NSLV*32-1:0] SLV_BASE       = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK       = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter int unsigned        TIMEOUT_CYCLES = 16,
  parameter logic [31:0]        ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  wb_addr_decoder_if.slave   bus,
  output logic               err_flag_o,
  output logic [1:0]         err_cause_o,
  output logic [31:0]        err_adr_o,
  input  logic               err_clr_i
);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            err_flag_q, err_flag_d;
  cause_t          err_cause_q, err_cause_d;
  logic [31:0]     err_adr_q, err_adr_d;

  logic            hit_s;
  logic [1:0]      idx_s;
  logic [NSLV-1:0] cyc_s, stb_s;
  logic            ack_s;
  logic [31:0]     dat_s;
  logic            fault_s;
  cause_t          fault_cause_s;

  wb_addr_match #(
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .adr_i (bus.wbs_adr_i),
    .hit_o (hit_s),
    .idx_o (idx_s)
  );

  assign bus.wbm_adr_o = bus.wbs_adr_i;
  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_we_o  = bus.wbs_we_i;
  assign bus.wbm_sel_o = bus.wbs_sel_i;

  // next-state, watchdog counter and per-state bus outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    cyc_s         = 4'b0000;
    stb_s         = 4'b0000;
    ack_s         = 1'b0;
    dat_s         = 32'h0000_0000;
    fault_s       = 1'b0;
    fault_cause_s = CAUSE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (hit_s) begin
            sel_d   = idx_s;
            cnt_d   = 16'd0;
            state_d = ST_BUSY;
          end else begin
            fault_s       = 1'b1;
            fault_cause_s = CAUSE_UNMAPPED;
            state_d       = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cyc_s[sel_q] = bus.wbs_cyc_i;
        stb_s[sel_q] = bus.wbs_stb_i;
        if (!bus.wbs_cyc_i) begin
          // master abandoned the cycle: no ack owed
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (bus.wbm_ack_i[sel_q]) begin
          // a slave ack on the last counted cycle still beats the timeout
          ack_s   = 1'b1;
          dat_s   = bus.wbm_dat_i[{sel_q, 5'd0} +: 32];
          cnt_d   = 16'd0;
          state_d = ST_DONE;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          fault_s       = 1'b1;
          fault_cause_s = CAUSE_TIMEOUT;
          cnt_d         = 16'd0;
          state_d       = ST_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        ack_s   = 1'b1;
        dat_s   = ERR_DATA;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // dead cycle so a strobe still being dropped is not re-decoded
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sticky first-fault capture; a new fault wins over a simultaneous clear
  always_comb begin
    err_flag_d  = err_flag_q;
    err_cause_d = err_cause_q;
    err_adr_d   = err_adr_q;
    if (fault_s && (!err_flag_q || err_clr_i)) begin
      err_flag_d  = 1'b1;
      err_cause_d = fault_cause_s;
      err_adr_d   = bus.wbs_adr_i;
    end else if (err_clr_i) begin
      err_flag_d  = 1'b0;
      err_cause_d = CAUSE_NONE;
      err_adr_d   = 32'h0000_0000;
    end else begin
      err_flag_d  = err_flag_q;
    end
  end

  // reset masks strobes and ack immediately, before the reset edge arrives
  always_comb begin
    if (wb_rst_n_i) begin
      bus.wbm_cyc_o = cyc_s;
      bus.wbm_stb_o = stb_s;
      bus.wbs_ack_o = ack_s;
      bus.wbs_dat_o = dat_s;
    end else begin
      bus.wbm_cyc_o = 4'b0000;
      bus.wbm_stb_o = 4'b0000;
      bus.wbs_ack_o = 1'b0;
      bus.wbs_dat_o = 32'h0000_0000;
    end
  end

  // state, counter, select and fault registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      sel_q       <= 2'd0;
      err_flag_q  <= 1'b0;
      err_cause_q <= CAUSE_NONE;
      err_adr_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      err_flag_q  <= err_flag_d;
      err_cause_q <= err_cause_d;
      err_adr_q   <= err_adr_d;
    end
  end

  assign err_flag_o  = err_flag_q;
  assign err_cause_o = err_cause_q;
  assign err_adr_o   = err_adr_q;

endmodule
